// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   owner_e : which requester owns the in-flight memory access
//   state_e : arbiter FSM states
//   NOP_INSTR : instruction returned for a misaligned fetch
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req_instr : instruction port requesting
//   req_data  : data port requesting
//   take      : the arbiter's grant is consumed this cycle (pointer may move)
//   gnt_valid : at least one request present
//   gnt_data  : 1 = data port wins, 0 = instruction port wins
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_instr,
  input  logic req_data,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_data
);

  owner_e last_reg;
  owner_e winner;

  always_comb begin
    winner = OWN_INSTR;
    if (req_instr && req_data) begin
      // Contention: the port that did not win last time goes now.
      winner = (last_reg == OWN_DATA) ? OWN_INSTR : OWN_DATA;
    end else if (req_data) begin
      winner = OWN_DATA;
    end
  end

  assign gnt_valid = req_instr | req_data;
  assign gnt_data  = (winner == OWN_DATA);

  // Resetting to "data" hands the very first contention to the fetch port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= OWN_DATA;
    end else if (take && gnt_valid) begin
      last_reg <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// word memory with one-cycle read latency. Each access takes two cycles:
// command issued in IDLE, ready pulse and read data returned in RESP.
//   clk, rst                     : clock, synchronous active-high reset
//   i_instr_req/addr             : fetch request (read only)
//   o_instr_ready/data           : fetch completion pulse and data
//   i_data_req/we/addr/wdata/be  : data request, write flag, byte enables
//   o_data_ready/rdata/err       : data completion pulse, data, misalign error
//   o_mem_en/we/idx/wdata        : memory command
//   i_mem_rdata                  : memory read data, one cycle after o_mem_en
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_instr_req,
  input  logic [ADDR_W-1:0] i_instr_addr,
  output logic              o_instr_ready,
  output logic [31:0]       o_instr_data,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [31:0]       i_data_wdata,
  input  logic [3:0]        i_data_be,
  output logic              o_data_ready,
  output logic [31:0]       o_data_rdata,
  output logic              o_data_err,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [IDX_W-1:0]  o_mem_idx,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  state_e state_reg, state_next;
  owner_e owner_reg, owner_next;
  logic   misal_reg, misal_next;

  logic              gnt_valid;
  logic              gnt_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_misal;
  logic              unused_addr_hi;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_instr (i_instr_req),
    .req_data  (i_data_req),
    .take      ((state_reg == ST_IDLE) && !rst),
    .gnt_valid (gnt_valid),
    .gnt_data  (gnt_data)
  );

  assign sel_addr  = gnt_data ? i_data_addr : i_instr_addr;
  assign sel_misal = |sel_addr[1:0];
  // Upper address bits alias onto the memory.
  assign unused_addr_hi = ^sel_addr[ADDR_W-1:IDX_W+2];

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    misal_next    = misal_reg;
    o_instr_ready = 1'b0;
    o_instr_data  = 32'd0;
    o_data_ready  = 1'b0;
    o_data_rdata  = 32'd0;
    o_data_err    = 1'b0;
    o_mem_en      = 1'b0;
    o_mem_we      = 4'b0000;
    o_mem_idx     = '0;
    o_mem_wdata   = 32'd0;

    case (state_reg)
      ST_IDLE: begin
        if (gnt_valid) begin
          // Misaligned accesses never touch memory but still take two cycles.
          o_mem_en  = !sel_misal;
          o_mem_idx = sel_addr[IDX_W+1:2];
          if (gnt_data && !sel_misal) begin
            o_mem_we    = i_data_we ? i_data_be : 4'b0000;
            o_mem_wdata = i_data_wdata;
          end
          state_next = ST_RESP;
          owner_next = gnt_data ? OWN_DATA : OWN_INSTR;
          misal_next = sel_misal;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        if (owner_reg == OWN_INSTR) begin
          o_instr_ready = 1'b1;
          o_instr_data  = misal_reg ? NOP_INSTR : i_mem_rdata;
        end else begin
          o_data_ready = 1'b1;
          o_data_err   = misal_reg;
          o_data_rdata = misal_reg ? 32'd0 : i_mem_rdata;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Reset silences everything, including a ready pulse due this cycle.
    if (rst) begin
      state_next    = ST_IDLE;
      o_instr_ready = 1'b0;
      o_instr_data  = 32'd0;
      o_data_ready  = 1'b0;
      o_data_rdata  = 32'd0;
      o_data_err    = 1'b0;
      o_mem_en      = 1'b0;
      o_mem_we      = 4'b0000;
      o_mem_idx     = '0;
      o_mem_wdata   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_INSTR;
      misal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      misal_reg <= misal_next;
    end
  end

endmodule
